// File: rtl/shaft_encoder_odometer.sv
// Left/right wheel shaft encoder conditioning, odometry and tick-distance move handshake.
// Define ODO_STALL_ABORT_EN to abort an active move with a moveFault pulse when either wheel stalls.

module shaft_encoder_side #(
    parameter int DEBOUNCE_CYCLES = 50_000,
    parameter int STALL_CYCLES    = 25_000_000,
    parameter int PERIOD_W        = 26,
    parameter int TICK_W          = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pulse_in,
    output logic                tick,
    output logic [TICK_W-1:0]   tick_count,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                stall
);
    localparam int                  DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]     DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] STALL_VAL  = PERIOD_W'(STALL_CYCLES);
    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                deb_q, deb_d;
    logic                deb_prev_q, deb_prev_d;
    logic                tick_q, tick_d;
    logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                period_valid_q, period_valid_d;
    logic                stall_q, stall_d;
    logic                armed_q, armed_d;

    always_comb begin
        sync1_d        = pulse_in;
        sync2_d        = sync1_q;
        deb_d          = deb_q;
        db_cnt_d       = '0;
        deb_prev_d     = deb_q;
        tick_d         = deb_q & ~deb_prev_q;
        tick_cnt_d     = tick_cnt_q;
        period_cnt_d   = period_cnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        stall_d        = stall_q;
        armed_d        = armed_q;

        // Any cycle where the synchronized input agrees with the accepted level restarts the count.
        if (sync2_q != deb_q) begin
            if (db_cnt_q == DB_LAST) begin
                deb_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        if (tick_q) begin
            tick_cnt_d   = tick_cnt_q + TICK_W'(1);
            period_cnt_d = '0;
            stall_d      = 1'b0;
            armed_d      = 1'b1;
            if (armed_q) begin
                period_d       = (period_cnt_q == PERIOD_MAX) ? PERIOD_MAX
                                                              : period_cnt_q + PERIOD_W'(1);
                period_valid_d = 1'b1;
            end
        end else begin
            if (period_cnt_q != PERIOD_MAX) begin
                period_cnt_d = period_cnt_q + PERIOD_W'(1);
            end
            // A stall invalidates the running interval, so the next tick only re-arms.
            if (period_cnt_d == STALL_VAL) begin
                stall_d = 1'b1;
                armed_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            deb_q          <= 1'b0;
            deb_prev_q     <= 1'b0;
            tick_q         <= 1'b0;
            db_cnt_q       <= '0;
            tick_cnt_q     <= '0;
            period_cnt_q   <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            stall_q        <= 1'b0;
            armed_q        <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            deb_q          <= deb_d;
            deb_prev_q     <= deb_prev_d;
            tick_q         <= tick_d;
            db_cnt_q       <= db_cnt_d;
            tick_cnt_q     <= tick_cnt_d;
            period_cnt_q   <= period_cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            stall_q        <= stall_d;
            armed_q        <= armed_d;
        end
    end

    assign tick         = tick_q;
    assign tick_count   = tick_cnt_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign stall        = stall_q;
endmodule

// Move handshake: a request is accepted on a cycle where cmdValid and cmdReady are both high;
// cmdReady is high only in IDLE and cmdTicks is sampled on that accepting cycle.
module shaft_encoder_odometer #(
    parameter int DEBOUNCE_CYCLES = 50_000,
    parameter int STALL_CYCLES    = 25_000_000,
    parameter int PERIOD_W        = 26,
    parameter int TICK_W          = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                shaftPulseL,
    input  logic                shaftPulseR,
    output logic [TICK_W-1:0]   tickCountL,
    output logic [TICK_W-1:0]   tickCountR,
    output logic [PERIOD_W-1:0] periodL,
    output logic [PERIOD_W-1:0] periodR,
    output logic                periodValidL,
    output logic                periodValidR,
    output logic                stallL,
    output logic                stallR,
    input  logic                cmdValid,
    output logic                cmdReady,
    input  logic [TICK_W-1:0]   cmdTicks,
    input  logic                cmdAbort,
    output logic                moveBusy,
    output logic                moveDone,
    output logic                moveFault,
    output logic [1:0]          move_state_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } move_state_e;

    localparam logic [TICK_W-1:0] TICK_MAX = '1;

    logic tick_l, tick_r;

    shaft_encoder_side #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .STALL_CYCLES   (STALL_CYCLES),
        .PERIOD_W       (PERIOD_W),
        .TICK_W         (TICK_W)
    ) u_side_l (
        .clk         (clk),
        .rst_n       (rst_n),
        .pulse_in    (shaftPulseL),
        .tick        (tick_l),
        .tick_count  (tickCountL),
        .period      (periodL),
        .period_valid(periodValidL),
        .stall       (stallL)
    );

    shaft_encoder_side #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .STALL_CYCLES   (STALL_CYCLES),
        .PERIOD_W       (PERIOD_W),
        .TICK_W         (TICK_W)
    ) u_side_r (
        .clk         (clk),
        .rst_n       (rst_n),
        .pulse_in    (shaftPulseR),
        .tick        (tick_r),
        .tick_count  (tickCountR),
        .period      (periodR),
        .period_valid(periodValidR),
        .stall       (stallR)
    );

    move_state_e       state_q, state_d;
    logic [TICK_W-1:0] target_q, target_d;
    logic [TICK_W-1:0] move_cnt_l_q, move_cnt_l_d;
    logic [TICK_W-1:0] move_cnt_r_q, move_cnt_r_d;
`ifdef ODO_STALL_ABORT_EN
    logic              fault_q, fault_d;
`endif

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        move_cnt_l_d = move_cnt_l_q;
        move_cnt_r_d = move_cnt_r_q;
`ifdef ODO_STALL_ABORT_EN
        fault_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (cmdValid) begin
                    target_d     = cmdTicks;
                    move_cnt_l_d = '0;
                    move_cnt_r_d = '0;
                    state_d      = (cmdTicks == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (tick_l && (move_cnt_l_q != TICK_MAX)) begin
                    move_cnt_l_d = move_cnt_l_q + TICK_W'(1);
                end
                if (tick_r && (move_cnt_r_q != TICK_MAX)) begin
                    move_cnt_r_d = move_cnt_r_q + TICK_W'(1);
                end
                // Abort outranks both completion and the stall abort.
                if (cmdAbort) begin
                    state_d = IDLE;
                end else if ((move_cnt_l_q >= target_q) && (move_cnt_r_q >= target_q)) begin
                    state_d = DONE;
                end
`ifdef ODO_STALL_ABORT_EN
                else if (stallL || stallR) begin
                    state_d = IDLE;
                    fault_d = 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            target_q     <= '0;
            move_cnt_l_q <= '0;
            move_cnt_r_q <= '0;
`ifdef ODO_STALL_ABORT_EN
            fault_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            move_cnt_l_q <= move_cnt_l_d;
            move_cnt_r_q <= move_cnt_r_d;
`ifdef ODO_STALL_ABORT_EN
            fault_q      <= fault_d;
`endif
        end
    end

    assign cmdReady       = (state_q == IDLE);
    assign moveBusy       = (state_q == RUN);
    assign moveDone       = (state_q == DONE);
    assign move_state_dbg = state_q;
`ifdef ODO_STALL_ABORT_EN
    assign moveFault      = fault_q;
`else
    assign moveFault      = 1'b0;
`endif
endmodule

// File: tb/tb_shaft_encoder_odometer.sv
// Directed bench for shaft_encoder_odometer: debounce vector table plus hand-written
// sequences for tick latency, period, move handshake, edge commands, stall and reset.

module tb_shaft_encoder_odometer;
    localparam int DEB   = 4;
    localparam int STALL = 200;
    localparam int PW    = 26;
    localparam int TW    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          shaftPulseL, shaftPulseR;
    logic [TW-1:0] tickCountL, tickCountR;
    logic [PW-1:0] periodL, periodR;
    logic          periodValidL, periodValidR;
    logic          stallL, stallR;
    logic          cmdValid, cmdReady, cmdAbort;
    logic [TW-1:0] cmdTicks;
    logic          moveBusy, moveDone, moveFault;
    logic [1:0]    move_state_dbg;

    shaft_encoder_odometer #(
        .DEBOUNCE_CYCLES(DEB),
        .STALL_CYCLES   (STALL),
        .PERIOD_W       (PW),
        .TICK_W         (TW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .shaftPulseL   (shaftPulseL),
        .shaftPulseR   (shaftPulseR),
        .tickCountL    (tickCountL),
        .tickCountR    (tickCountR),
        .periodL       (periodL),
        .periodR       (periodR),
        .periodValidL  (periodValidL),
        .periodValidR  (periodValidR),
        .stallL        (stallL),
        .stallR        (stallR),
        .cmdValid      (cmdValid),
        .cmdReady      (cmdReady),
        .cmdTicks      (cmdTicks),
        .cmdAbort      (cmdAbort),
        .moveBusy      (moveBusy),
        .moveDone      (moveDone),
        .moveFault     (moveFault),
        .move_state_dbg(move_state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          side;
        logic [15:0] pattern;
        int          len;
        int          exp_ticks;
    } deb_vec_t;

    deb_vec_t      vecs[7];
    int            n_vec  = 0;
    int            n_fail = 0;
    int            cyc    = 0;
    int            done_cnt;
    int            fault_cnt;
    int            done_step;
    int            last_rise_r;
    logic [TW-1:0] exp_cnt_l, exp_cnt_r;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] exp_v;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (moveDone === 1'b1) done_cnt++;
        if (moveFault === 1'b1) fault_cnt++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse(input bit side);
        if (side) begin
            shaftPulseR = 1'b1;
            last_rise_r = cyc;
        end else begin
            shaftPulseL = 1'b1;
        end
        repeat (6) step();
        if (side) shaftPulseR = 1'b0;
        else shaftPulseL = 1'b0;
        repeat (8) step();
        if (side) exp_cnt_r++;
        else exp_cnt_l++;
    endtask

    task automatic send_cmd(input logic [TW-1:0] ticks);
        cmdValid = 1'b1;
        cmdTicks = ticks;
        step();
        cmdValid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got %0d cycles, expected completion", cyc);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 16'h0007, 3, 0};   // 3 high cycles: rejected
        vecs[1] = '{1'b0, 16'h03FF, 10, 1};  // 10 high cycles: one tick
        vecs[2] = '{1'b0, 16'h000F, 4, 1};   // exactly DEB high cycles: accepted
        vecs[3] = '{1'b0, 16'hFEFF, 16, 1};  // one-cycle dropout inside a high level
        vecs[4] = '{1'b1, 16'h0077, 7, 0};   // 3 high, 1 low, 3 high: count restarts
        vecs[5] = '{1'b1, 16'h001F, 5, 1};
        vecs[6] = '{1'b1, 16'h001B, 5, 0};

        rst_n = 1'b0; shaftPulseL = 1'b0; shaftPulseR = 1'b0;
        cmdValid = 1'b0; cmdTicks = '0; cmdAbort = 1'b0;
        exp_cnt_l = '0; exp_cnt_r = '0;
        done_cnt = 0; fault_cnt = 0; done_step = 0; last_rise_r = 0;

        // Reset
        repeat (3) step();
        rst_n = 1'b1;
        check("rst cmdReady", 32'(cmdReady), 32'd1);
        check("rst tickCountL", 32'(tickCountL), 32'd0);
        check("rst tickCountR", 32'(tickCountR), 32'd0);
        check("rst periodL", 32'(periodL), 32'd0);
        check("rst periodR", 32'(periodR), 32'd0);
        check("rst periodValidL", 32'(periodValidL), 32'd0);
        check("rst stallL", 32'(stallL), 32'd0);
        check("rst stallR", 32'(stallR), 32'd0);
        check("rst moveBusy", 32'(moveBusy), 32'd0);
        check("rst moveDone", 32'(moveDone), 32'd0);
        check("rst moveFault", 32'(moveFault), 32'd0);

        // Debounce vector table
        for (int i = 0; i < 7; i++) begin
            for (int b = 0; b < vecs[i].len; b++) begin
                if (vecs[i].side) shaftPulseR = vecs[i].pattern[b];
                else shaftPulseL = vecs[i].pattern[b];
                step();
            end
            shaftPulseL = 1'b0;
            shaftPulseR = 1'b0;
            repeat (12) step();
            if (vecs[i].side) exp_cnt_r = exp_cnt_r + TW'(vecs[i].exp_ticks);
            else exp_cnt_l = exp_cnt_l + TW'(vecs[i].exp_ticks);
            check($sformatf("deb vec%0d tickCountL", i), 32'(tickCountL), 32'(exp_cnt_l));
            check($sformatf("deb vec%0d tickCountR", i), 32'(tickCountR), 32'(exp_cnt_r));
        end

        // Tick latency: tick 6 cycles after the first sampling edge, count one cycle later
        shaftPulseL = 1'b1;
        repeat (7) step();
        check("latency count before", 32'(tickCountL), 32'(exp_cnt_l));
        step();
        exp_cnt_l++;
        check("latency count after", 32'(tickCountL), 32'(exp_cnt_l));
        shaftPulseL = 1'b0;
        repeat (10) step();

        // Period: idle long enough to stall, then pulses every 100 cycles
        repeat (250) step();
        check("idle stallL", 32'(stallL), 32'd1);
        repeat (3) exp_q.push_back(PW'(100));
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < 100; s++) begin
                shaftPulseL = (s < 20);
                step();
                if (periodValidL) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL periodValidL unexpected: got period %0d, expected no pulse", periodL);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (periodL !== exp_v) begin
                            n_fail++;
                            $display("FAIL periodL: got %0d, expected %0d", periodL, exp_v);
                        end
                    end
                end
            end
            if (k == 0) check("stallL cleared by tick", 32'(stallL), 32'd0);
        end
        shaftPulseL = 1'b0;
        exp_cnt_l = exp_cnt_l + TW'(4);
        check("period queue drained", 32'(exp_q.size()), 32'd0);
        check("periodL held", 32'(periodL), 32'd100);

        // Move of 5 ticks
        pulse(1'b0); pulse(1'b1);
        done_cnt = 0;
        send_cmd(TW'(5));
        check("move busy", 32'(moveBusy), 32'd1);
        check("move cmdReady low", 32'(cmdReady), 32'd0);
        send_cmd(TW'(0));
        check("cmdValid ignored in RUN", 32'(moveBusy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            pulse(1'b0);
            if (i < 4) pulse(1'b1);
        end
        check("move busy after L5 R4", 32'(moveBusy), 32'd1);
        check("move no done yet", 32'(done_cnt), 32'd0);
        done_step = 0;
        shaftPulseR = 1'b1;
        for (int s = 1; s <= 14; s++) begin
            if (s == 7) shaftPulseR = 1'b0;
            step();
            if (moveDone && done_step == 0) done_step = s;
        end
        exp_cnt_r++;
        check("moveDone step", 32'(done_step), 32'd9);
        check("moveDone count", 32'(done_cnt), 32'd1);
        check("move cmdReady after", 32'(cmdReady), 32'd1);
        check("move tickCountL", 32'(tickCountL), 32'(exp_cnt_l));
        check("move tickCountR", 32'(tickCountR), 32'(exp_cnt_r));

        // Zero-length move
        done_cnt = 0;
        send_cmd(TW'(0));
        check("zero move done", 32'(moveDone), 32'd1);
        step();
        check("zero move done drops", 32'(moveDone), 32'd0);
        check("zero move ready", 32'(cmdReady), 32'd1);
        repeat (4) step();
        check("zero move one done", 32'(done_cnt), 32'd1);

        // Abort on the completing cycle
        pulse(1'b0); pulse(1'b1);
        send_cmd(TW'(1));
        pulse(1'b0);
        done_cnt = 0;
        shaftPulseR = 1'b1;
        for (int s = 1; s <= 14; s++) begin
            if (s == 7) shaftPulseR = 1'b0;
            cmdAbort = (s == 9);
            step();
        end
        cmdAbort = 1'b0;
        exp_cnt_r++;
        check("abort no done", 32'(done_cnt), 32'd0);
        check("abort ready", 32'(cmdReady), 32'd1);
        check("abort not busy", 32'(moveBusy), 32'd0);

        // Stall during a move
        pulse(1'b0); pulse(1'b1);
        send_cmd(TW'(3));
        done_cnt = 0;
        fault_cnt = 0;
        for (int i = 0; i < 3; i++) pulse(1'b0);
        for (int k = 0; k < 400 && !stallR; k++) step();
        check("stallR set", 32'(stallR), 32'd1);
        check("stallR latency", 32'(cyc - last_rise_r), 32'd208);
        repeat (2) step();
`ifdef ODO_STALL_ABORT_EN
        check("stall fault pulses", 32'(fault_cnt), 32'd1);
        check("stall abort ready", 32'(cmdReady), 32'd1);
        check("stall abort not busy", 32'(moveBusy), 32'd0);
        check("stall abort no done", 32'(done_cnt), 32'd0);
        for (int i = 0; i < 3; i++) pulse(1'b1);
`else
        check("stall still busy", 32'(moveBusy), 32'd1);
        check("stall no fault", 32'(fault_cnt), 32'd0);
        for (int i = 0; i < 3; i++) pulse(1'b1);
        check("stall move completes", 32'(done_cnt), 32'd1);
        check("stall move ready", 32'(cmdReady), 32'd1);
`endif
        check("stallR cleared", 32'(stallR), 32'd0);
        check("stall tickCountR", 32'(tickCountR), 32'(exp_cnt_r));

        // Reset in the middle of a move
        pulse(1'b0); pulse(1'b1);
        send_cmd(TW'(5));
        check("pre-reset busy", 32'(moveBusy), 32'd1);
        pulse(1'b0);
        done_cnt = 0;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        exp_cnt_l = '0;
        exp_cnt_r = '0;
        check("mid reset ready", 32'(cmdReady), 32'd1);
        check("mid reset not busy", 32'(moveBusy), 32'd0);
        check("mid reset tickCountL", 32'(tickCountL), 32'(exp_cnt_l));
        check("mid reset periodL", 32'(periodL), 32'd0);
        repeat (20) step();
        check("mid reset no done", 32'(done_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
